// File: rtl/sim_clock_monitor_pkg.sv
// ============================================================================
// Module      : sim_clock_monitor_pkg
// Description : Shared HIL definitions for the sim-clock monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sim_clock_monitor_pkg;

  typedef enum logic [1:0] {
    ST_NO_CLK  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } mon_state_e;

  localparam int unsigned NOMINAL_PERIOD = 500;
  localparam int unsigned SYNC_DEPTH     = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sim_clock_monitor_sync_edge_detect.sv
// ============================================================================
// Module      : sim_clock_monitor_sync_edge_detect
// Description : Three-flop synchronizer with a registered rising-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_clock_monitor_sync_edge_detect
  import sim_clock_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic                  r_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_async};
      r_edge <= r_sync[SYNC_DEPTH-2] & ~r_sync[SYNC_DEPTH-1];
    end
  end

  assign o_edge = r_edge;

endmodule

`default_nettype wire

// File: rtl/sim_clock_monitor.sv
// ============================================================================
// Module      : sim_clock_monitor
// Description : Measures an asynchronous sim clock period and tracks lock/fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_clock_monitor
  import sim_clock_monitor_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int PERIOD_MIN = NOMINAL_PERIOD - 10,
  parameter int PERIOD_MAX = NOMINAL_PERIOD + 10,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 1000
) (
  input  logic             clk_50Mhz,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             fault_clr,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [7:0]       err_count
);

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_PMIN    = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] c_PMAX    = CNT_W'(PERIOD_MAX);
  localparam logic [3:0]       c_LOCK    = 4'(LOCK_COUNT);

  logic             w_edge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_meas;
  logic             w_in_range;
  logic             w_timeout;
  logic             w_pv;
  mon_state_e       r_state, w_state_nxt;
  logic [3:0]       r_good, w_good_nxt;
  logic [7:0]       r_err, w_err_nxt;

  sim_clock_monitor_sync_edge_detect u_sync (
    .clk     (clk_50Mhz),
    .rst     (reset),
    .i_async (clk_in),
    .o_edge  (w_edge)
  );

  // cnt holds TIMEOUT once reached so a missing clock never wraps into range
  always_ff @(posedge clk_50Mhz) begin
    if (reset)                r_cnt <= '0;
    else if (w_edge)          r_cnt <= '0;
    else if (r_cnt != c_TIMEOUT) r_cnt <= r_cnt + 1'b1;
  end

  assign w_meas     = r_cnt + 1'b1;
  assign w_in_range = (w_meas >= c_PMIN) && (w_meas <= c_PMAX);
  assign w_timeout  = (r_cnt == c_TIMEOUT) && !w_edge;
  assign w_pv       = w_edge && (r_state != ST_NO_CLK) && !fault_clr;

  always_ff @(posedge clk_50Mhz) begin
    if (reset)     r_period <= '0;
    else if (w_pv) r_period <= w_meas;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err_nxt   = r_err;
    if (fault_clr) begin
      // Clear wins over any coincident edge or timeout
      w_err_nxt = 8'd0;
      if (r_state == ST_FAULT) begin
        w_state_nxt = ST_NO_CLK;
        w_good_nxt  = 4'd0;
      end
    end else begin
      case (r_state)
        ST_NO_CLK: begin
          if (w_edge) begin
            w_state_nxt = ST_ACQUIRE;
            w_good_nxt  = 4'd0;
          end
        end
        ST_ACQUIRE: begin
          if (w_edge) begin
            if (w_in_range) begin
              if (r_good + 4'd1 == c_LOCK) begin
                w_state_nxt = ST_LOCKED;
                w_good_nxt  = 4'd0;
              end else begin
                w_good_nxt = r_good + 4'd1;
              end
            end else begin
              w_good_nxt = 4'd0;
              w_err_nxt  = sat_inc8(r_err);
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_NO_CLK;
            w_good_nxt  = 4'd0;
            w_err_nxt   = sat_inc8(r_err);
          end
        end
        ST_LOCKED: begin
          if ((w_edge && !w_in_range) || w_timeout) begin
            w_state_nxt = ST_FAULT;
            w_err_nxt   = sat_inc8(r_err);
          end
        end
        ST_FAULT: begin
          if ((w_edge && !w_in_range) || w_timeout) w_err_nxt = sat_inc8(r_err);
        end
        default: w_state_nxt = ST_NO_CLK;
      endcase
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (reset) begin
      r_state <= ST_NO_CLK;
      r_good  <= 4'd0;
      r_err   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign edge_pulse   = w_edge;
  assign period_valid = w_pv;
  assign period       = w_pv ? w_meas : r_period;
  assign locked       = (r_state == ST_LOCKED);
  assign fault        = (r_state == ST_FAULT);
  assign err_count    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sim_clock_monitor.sv
// ============================================================================
// Module      : tb_sim_clock_monitor
// Description : Directed, table-driven bench for sim_clock_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_clock_monitor;

  logic       clk;
  logic       reset;
  logic       clk_in;
  logic       fault_clr;
  logic       edge_pulse;
  logic [9:0] period;
  logic       period_valid;
  logic       locked;
  logic       fault;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;
  int since_pulse = 0;

  // One entry = one clk_in period driven from a rising edge; expectations
  // describe the pulse seen inside that window and the state at its end.
  typedef struct {
    int per;
    int clr_at;
    int rst_at;
    int exp_pv;
    int exp_period;
    int exp_locked;
    int exp_fault;
    int exp_err;
  } vec_t;

  vec_t tbl [28];

  sim_clock_monitor dut (
    .clk_50Mhz    (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .fault_clr    (fault_clr),
    .edge_pulse   (edge_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .fault        (fault),
    .err_count    (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_window(input int idx);
    vec_t v;
    int   pk;
    int   npulse;
    int   npv;
    int   per_at;
    v      = tbl[idx];
    pk     = -1;
    npulse = 0;
    npv    = 0;
    per_at = 0;
    for (int k = 0; k < v.per; k++) begin
      @(negedge clk);
      clk_in    = (k < v.per / 2);
      fault_clr = (k == v.clr_at);
      reset     = (k == v.rst_at);
      #1;
      if (edge_pulse) begin
        npulse++;
        if (pk < 0) pk = k;
        since_pulse = 0;
      end else begin
        since_pulse++;
      end
      if (period_valid) begin
        npv++;
        per_at = int'(period);
      end
      if (v.rst_at >= 0 && k == v.rst_at)
        chk($sformatf("w%0d pre_reset_locked", idx), int'(locked), 1);
      if (v.rst_at >= 0 && k == v.rst_at + 1) begin
        chk($sformatf("w%0d rst_edge_pulse", idx), int'(edge_pulse), 0);
        chk($sformatf("w%0d rst_period_valid", idx), int'(period_valid), 0);
        chk($sformatf("w%0d rst_period", idx), int'(period), 0);
        chk($sformatf("w%0d rst_locked", idx), int'(locked), 0);
        chk($sformatf("w%0d rst_fault", idx), int'(fault), 0);
        chk($sformatf("w%0d rst_err_count", idx), int'(err_count), 0);
      end
    end
    chk($sformatf("w%0d edge_latency", idx), pk, 3);
    chk($sformatf("w%0d edge_count", idx), npulse, 1);
    chk($sformatf("w%0d period_valid_count", idx), npv, v.exp_pv);
    if (v.exp_pv == 1) chk($sformatf("w%0d period", idx), per_at, v.exp_period);
    chk($sformatf("w%0d locked", idx), int'(locked), v.exp_locked);
    chk($sformatf("w%0d fault", idx), int'(fault), v.exp_fault);
    chk($sformatf("w%0d err_count", idx), int'(err_count), v.exp_err);
  endtask

  initial begin
    int n;
    //            per  clr rst  pv  period lk  ft  err
    tbl[0]  = '{500, -1, -1, 0,   0, 0, 0, 0};
    tbl[1]  = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[2]  = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[3]  = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[4]  = '{520, -1, -1, 1, 500, 1, 0, 0};
    tbl[5]  = '{500, -1, -1, 1, 520, 0, 1, 1};
    tbl[6]  = '{489, -1, -1, 1, 500, 0, 1, 1};
    tbl[7]  = '{500, -1, -1, 1, 489, 0, 1, 2};
    tbl[8]  = '{500,  3, -1, 0,   0, 0, 0, 0};
    tbl[9]  = '{500, -1, -1, 0,   0, 0, 0, 0};
    tbl[10] = '{489, -1, -1, 1, 500, 0, 0, 0};
    tbl[11] = '{511, -1, -1, 1, 489, 0, 0, 1};
    tbl[12] = '{500, -1, -1, 1, 511, 0, 0, 2};
    tbl[13] = '{490, -1, -1, 1, 500, 0, 0, 2};
    tbl[14] = '{510, -1, -1, 1, 490, 0, 0, 2};
    tbl[15] = '{500, -1, -1, 1, 510, 0, 0, 2};
    tbl[16] = '{500, -1, -1, 1, 500, 1, 0, 2};
    tbl[17] = '{500, -1, -1, 1, 500, 1, 0, 2};
    tbl[18] = '{500, -1, -1, 0,   0, 0, 0, 0};
    tbl[19] = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[20] = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[21] = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[22] = '{500, -1, 250, 1, 500, 0, 0, 0};
    tbl[23] = '{500, -1, -1, 0,   0, 0, 0, 0};
    tbl[24] = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[25] = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[26] = '{500, -1, -1, 1, 500, 0, 0, 0};
    tbl[27] = '{500, -1, -1, 1, 500, 1, 0, 0};

    reset     = 1'b1;
    clk_in    = 1'b0;
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset edge_pulse", int'(edge_pulse), 0);
    chk("reset period_valid", int'(period_valid), 0);
    chk("reset period", int'(period), 0);
    chk("reset locked", int'(locked), 0);
    chk("reset fault", int'(fault), 0);
    chk("reset err_count", int'(err_count), 0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 18; i++) run_window(i);

    // Locked, then clk_in stops: cnt hits TIMEOUT 1001 cycles after the
    // pulse cycle and the FAULT state shows one cycle later.
    n = 0;
    while (!fault && n < 1500) begin
      @(negedge clk);
      clk_in = 1'b0;
      #1;
      if (edge_pulse) since_pulse = 0;
      else            since_pulse++;
      n++;
    end
    chk("timeout fault", int'(fault), 1);
    chk("timeout delay", since_pulse, 1002);
    chk("timeout locked", int'(locked), 0);
    chk("timeout err_count", int'(err_count), 3);

    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    #1;
    chk("clear fault", int'(fault), 0);
    chk("clear err_count", int'(err_count), 0);
    chk("clear locked", int'(locked), 0);

    for (int i = 18; i < 28; i++) run_window(i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
